home_inventory_wbm_seq: RTL

//  Single-outstanding Wishbone initiator. Converts valid/ready command beats (read/write, addr, data, sel)

---
 rtl/home_inventory_wbm_seq.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/home_inventory_wbm_seq.sv
// home_inventory_wbm_seq
//   Single-outstanding Wishbone (classic) initiator. A valid/ready command
//   beat becomes one Wishbone cycle. A valid/ready response beat returns the
//   read data and the error status.
//
// Parameters
//   TIMEOUT_CYCLES : REQ cycles without ack before an abort (1..65535).
//                    Used only when HIW_WBM_TIMEOUT_EN is defined.
//   ALIGN_ADDR     : 1 forces wbm_adr_o[1:0] to 2'b00; 0 passes cmd_adr through.
//
// Optional feature macro
//   HIW_WBM_TIMEOUT_EN : enables the REQ timeout counter. When this macro is
//                        undefined, REQ waits for ack indefinitely and
//                        rsp_err is tied to 0.
//
// Ports
//   wb_clk_i, wb_rst_i           : clock, synchronous active-high reset
//   cmd_valid/cmd_ready          : command handshake
//   cmd_we/cmd_adr/cmd_dat/cmd_sel : command payload
//   rsp_valid/rsp_ready          : response handshake
//   rsp_dat, rsp_err             : read data (0 for writes and errors), timeout flag
//   wbm_cyc_o/stb_o/we_o/sel_o/adr_o/dat_o : Wishbone request (all registered)
//   wbm_dat_i, wbm_ack_i         : Wishbone response
//   busy                         : high in REQ or RESP
module home_inventory_wbm_seq #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter bit          ALIGN_ADDR     = 1'b1
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_we,
   input  logic [31:0] cmd_adr,
   input  logic [31:0] cmd_dat,
   input  logic [3:0]  cmd_sel,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_dat,
   output logic        rsp_err,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   output logic        busy
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_e;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be in 1..65535");
   end

   state_e      state_q, state_d;
   logic        cmd_ready_q, cmd_ready_d;
   logic        cyc_q, cyc_d;
   logic        we_q, we_d;
   logic [3:0]  sel_q, sel_d;
   logic [31:0] adr_q, adr_d;
   logic [31:0] wdat_q, wdat_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_dat_q, rsp_dat_d;
`ifdef HIW_WBM_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] cnt_q, cnt_d;
   logic        rsp_err_q, rsp_err_d;
`endif

   always_comb begin
      // NOTE: every signal gets its hold value first, so no branch can leave
      // one unassigned and infer a latch.
      state_d     = state_q;
      cyc_d       = cyc_q;
      we_d        = we_q;
      sel_d       = sel_q;
      adr_d       = adr_q;
      wdat_d      = wdat_q;
      rsp_valid_d = rsp_valid_q;
      rsp_dat_d   = rsp_dat_q;
`ifdef HIW_WBM_TIMEOUT_EN
      cnt_d       = cnt_q;
      rsp_err_d   = rsp_err_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            // Accept on the registered ready, the same value the initiator sees.
            if (cmd_valid && cmd_ready_q) begin
               we_d    = cmd_we;
               sel_d   = cmd_sel;
               adr_d   = ALIGN_ADDR ? {cmd_adr[31:2], 2'b00} : cmd_adr;
               wdat_d  = cmd_dat;
               cyc_d   = 1'b1;
               state_d = S_REQ;
`ifdef HIW_WBM_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         S_REQ: begin
            // Dropping stb on the edge after ack keeps the responder's ~ack
            // guard from seeing a second request.
            if (wbm_ack_i) begin
               rsp_dat_d   = we_q ? 32'h0 : wbm_dat_i;
               cyc_d       = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
`ifdef HIW_WBM_TIMEOUT_EN
               rsp_err_d   = 1'b0;
            end else if (cnt_q == TO_LAST) begin
               rsp_dat_d   = 32'h0;
               rsp_err_d   = 1'b1;
               cyc_d       = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
            end else begin
               cnt_d = cnt_q + 16'd1;
`endif
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Ready is registered, so it is 0 while reset is held and 1 in the
      // cycle after reset.
      cmd_ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge wb_clk_i) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values of the others.
      if (wb_rst_i) begin
         state_q     <= S_IDLE;
         cmd_ready_q <= 1'b0;
         cyc_q       <= 1'b0;
         we_q        <= 1'b0;
         sel_q       <= '0;
         adr_q       <= '0;
         wdat_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_dat_q   <= '0;
`ifdef HIW_WBM_TIMEOUT_EN
         cnt_q       <= '0;
         rsp_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         cyc_q       <= cyc_d;
         we_q        <= we_d;
         sel_q       <= sel_d;
         adr_q       <= adr_d;
         wdat_q      <= wdat_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_dat_q   <= rsp_dat_d;
`ifdef HIW_WBM_TIMEOUT_EN
         cnt_q       <= cnt_d;
         rsp_err_q   <= rsp_err_d;
`endif
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_dat   = rsp_dat_q;
`ifdef HIW_WBM_TIMEOUT_EN
   assign rsp_err   = rsp_err_q;
`else
   assign rsp_err   = 1'b0;
`endif
   assign wbm_cyc_o = cyc_q;
   assign wbm_stb_o = cyc_q;
   assign wbm_we_o  = we_q;
   assign wbm_sel_o = sel_q;
   assign wbm_adr_o = adr_q;
   assign wbm_dat_o = wdat_q;
   assign busy      = (state_q == S_REQ) || (state_q == S_RESP);

endmodule
